wb_scoreboard: RTL and testbench

WB_SCOREBOARD -- requirements
Module: wb_scoreboard

---
 rtl/wb_scoreboard.sv | 123 ++++++++++++
 tb/tb_wb_scoreboard.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - register busy scoreboard with writeback arbitration (alu > mem/fpu with fpu anti-starvation)
module wb_scoreboard #(
   parameter int LEN_REG      = 32,
   parameter int NUM_REG      = 32,
   parameter int LEN_REG_ADDR = $clog2(NUM_REG)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    issue_valid,
   input  logic [LEN_REG_ADDR-1:0] issue_rd,
   input  logic [LEN_REG_ADDR-1:0] ars1,
   input  logic [LEN_REG_ADDR-1:0] ars2,
   output logic                    issue_stall,
   input  logic                    alu_valid,
   input  logic [LEN_REG_ADDR-1:0] alu_rd,
   input  logic [LEN_REG-1:0]      alu_data,
   input  logic                    mem_valid,
   output logic                    mem_ready,
   input  logic [LEN_REG_ADDR-1:0] mem_rd,
   input  logic [LEN_REG-1:0]      mem_data,
   input  logic                    fpu_valid,
   output logic                    fpu_ready,
   input  logic [LEN_REG_ADDR-1:0] fpu_rd,
   input  logic [LEN_REG-1:0]      fpu_data,
   output logic                    out_we,
   output logic [LEN_REG_ADDR-1:0] out_rd,
   output logic [LEN_REG-1:0]      out_data
);

   // fpu is forced through once it has lost this many consecutive cycles
   localparam logic [2:0] STARVE_MAX = 3'd4;

   logic [NUM_REG-1:0]      busy_q, busy_d;
   logic [2:0]              starve_q, starve_d;
   logic                    out_we_q, out_we_d;
   logic [LEN_REG_ADDR-1:0] out_rd_q, out_rd_d;
   logic [LEN_REG-1:0]      out_data_q, out_data_d;

   logic                    alu_take, mem_take, fpu_take;

   assign out_we   = out_we_q;
   assign out_rd   = out_rd_q;
   assign out_data = out_data_q;

   // hazard check against registered busy only; a write retiring this cycle does not unblock
   always_comb begin
      issue_stall = issue_valid & (busy_q[ars1] | busy_q[ars2] | busy_q[issue_rd]);
   end

   // grant one writeback source: alu always, else mem unless fpu has starved long enough
   always_comb begin
      alu_take = alu_valid;
      mem_take = 1'b0;
      fpu_take = 1'b0;
      if (!alu_valid) begin
         if (fpu_valid && (!mem_valid || starve_q == STARVE_MAX)) begin
            fpu_take = 1'b1;
         end else begin
            mem_take = mem_valid;
         end
      end
      mem_ready = mem_take;
      fpu_ready = fpu_take;
   end

   // count consecutive cycles the fpu waited; any idle or granted cycle restarts the count
   always_comb begin
      starve_d = 3'd0;
      if (fpu_valid && !fpu_take) begin
         starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 3'd1;
      end
   end

   // register the granted result; rd 0 completes the handshake but never writes
   always_comb begin
      out_we_d   = 1'b0;
      out_rd_d   = out_rd_q;
      out_data_d = out_data_q;
      if (alu_take) begin
         out_rd_d   = alu_rd;
         out_data_d = alu_data;
         out_we_d   = (alu_rd != '0);
      end else if (mem_take) begin
         out_rd_d   = mem_rd;
         out_data_d = mem_data;
         out_we_d   = (mem_rd != '0);
      end else if (fpu_take) begin
         out_rd_d   = fpu_rd;
         out_data_d = fpu_data;
         out_we_d   = (fpu_rd != '0);
      end
   end

   // clear on the register-file write, then set on issue so a same-edge reissue stays busy
   always_comb begin
      busy_d = busy_q;
      if (out_we_q) begin
         busy_d[out_rd_q] = 1'b0;
      end
      if (issue_valid && !issue_stall && issue_rd != '0) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // state registers; reset drops any write accepted in the reset cycle
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_q     <= '0;
         starve_q   <= 3'd0;
         out_we_q   <= 1'b0;
         out_rd_q   <= '0;
         out_data_q <= '0;
      end else begin
         busy_q     <= busy_d;
         starve_q   <= starve_d;
         out_we_q   <= out_we_d;
         out_rd_q   <= out_rd_d;
         out_data_q <= out_data_d;
      end
   end

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb/tb_wb_scoreboard.sv - directed and random checks of wb_scoreboard against a behavioural model
module tb_wb_scoreboard;

   logic        clk = 1'b0;
   logic        rstn;
   logic        issue_valid;
   logic [4:0]  issue_rd, ars1, ars2;
   logic        issue_stall;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid, mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        fpu_valid, fpu_ready;
   logic [4:0]  fpu_rd;
   logic [31:0] fpu_data;
   logic        out_we;
   logic [4:0]  out_rd;
   logic [31:0] out_data;

   always #5 clk = ~clk;

   wb_scoreboard dut (
      .clk(clk), .rstn(rstn),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .ars1(ars1), .ars2(ars2),
      .issue_stall(issue_stall),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
      .out_we(out_we), .out_rd(out_rd), .out_data(out_data)
   );

   int n_assert = 0;
   int n_fail   = 0;

   localparam int W_NONE = 0, W_ALU = 1, W_MEM = 2, W_FPU = 3;

   bit [31:0]   busy_m;
   int          starve_m;
   logic        exp_we;
   logic [4:0]  exp_rd;
   logic [31:0] exp_data;
   logic        stall_m;
   int          win_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_comb();
      stall_m = issue_valid && (busy_m[ars1] || busy_m[ars2] || busy_m[issue_rd]);
      if (alu_valid)                   win_m = W_ALU;
      else if (mem_valid && fpu_valid) win_m = (starve_m >= 4) ? W_FPU : W_MEM;
      else if (mem_valid)              win_m = W_MEM;
      else if (fpu_valid)              win_m = W_FPU;
      else                             win_m = W_NONE;
   endtask

   task automatic model_edge();
      if (!rstn) begin
         busy_m   = '0;
         starve_m = 0;
         exp_we   = 1'b0;
         exp_rd   = '0;
         exp_data = '0;
      end else begin
         if (exp_we) busy_m[exp_rd] = 1'b0;
         if (issue_valid && !stall_m && issue_rd != 0) busy_m[issue_rd] = 1'b1;
         if (fpu_valid && win_m != W_FPU) starve_m = (starve_m < 4) ? starve_m + 1 : 4;
         else starve_m = 0;
         case (win_m)
            W_ALU: begin exp_rd = alu_rd; exp_data = alu_data; end
            W_MEM: begin exp_rd = mem_rd; exp_data = mem_data; end
            W_FPU: begin exp_rd = fpu_rd; exp_data = fpu_data; end
            default: ;
         endcase
         exp_we = (win_m != W_NONE) && (exp_rd != 0);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_comb();
      check("issue_stall", issue_stall, stall_m);
      check("mem_ready", mem_ready, win_m == W_MEM);
      check("fpu_ready", fpu_ready, win_m == W_FPU);
      @(posedge clk);
      model_edge();
      #1;
      check("out_we", out_we, exp_we);
      check("out_rd", out_rd, exp_rd);
      check("out_data", out_data, exp_data);
   endtask

   task automatic idle();
      issue_valid = 0; issue_rd = 0; ars1 = 0; ars2 = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      fpu_valid = 0; fpu_rd = 0; fpu_data = 0;
   endtask

   task automatic do_reset();
      idle();
      rstn = 0;
      cycle();
      rstn = 1;
   endtask

   initial begin
      logic [4:0] mseq, fseq;
      busy_m = '0; starve_m = 0; exp_we = 0; exp_rd = 0; exp_data = 0;
      idle();
      rstn = 0;
      cycle();
      cycle();
      check("rst_out_we", out_we, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_out_data", out_data, 0);
      rstn = 1;

      // load-use hazard on r5 resolved by a mem result
      issue_valid = 1; issue_rd = 5; ars1 = 0; ars2 = 0;
      cycle();
      issue_rd = 6; ars1 = 5;
      cycle();
      check("r34_stall", issue_stall, 1);
      mem_valid = 1; mem_rd = 5; mem_data = 32'hDEADBEEF;
      cycle();
      check("r34_we", out_we, 1);
      check("r34_rd", out_rd, 5);
      check("r34_data", out_data, 32'hDEADBEEF);
      mem_valid = 0;
      cycle();
      check("r34_stall_clear", issue_stall, 0);
      issue_valid = 0;
      cycle();

      // alu beats mem and fpu
      do_reset();
      alu_valid = 1; alu_rd = 10; alu_data = 32'h0A;
      mem_valid = 1; mem_rd = 11; mem_data = 32'h0B;
      fpu_valid = 1; fpu_rd = 12; fpu_data = 32'h0C;
      #1;
      check("r35_mem_ready", mem_ready, 0);
      check("r35_fpu_ready", fpu_ready, 0);
      cycle();
      check("r35_out_rd", out_rd, 10);
      alu_valid = 0;
      cycle();
      mem_valid = 0;
      cycle();
      fpu_valid = 0;
      cycle();

      // fpu starvation relief every fifth contested cycle
      do_reset();
      mseq = 1; fseq = 20;
      for (int i = 0; i < 10; i++) begin
         mem_valid = 1; mem_rd = mseq; mem_data = 32'h100 + i;
         fpu_valid = 1; fpu_rd = fseq; fpu_data = 32'h200 + i;
         #1;
         check("r36_fpu_ready", fpu_ready, (i == 4 || i == 9));
         check("r36_mem_ready", mem_ready, !(i == 4 || i == 9));
         cycle();
         if (i == 4 || i == 9) fseq = fseq + 1;
         else mseq = mseq + 1;
      end
      idle();
      cycle();

      // rd 0 result completes but does not write
      do_reset();
      issue_valid = 1; issue_rd = 9;
      cycle();
      issue_valid = 0;
      fpu_valid = 1; fpu_rd = 0; fpu_data = 32'h1234;
      #1;
      check("r37_fpu_ready", fpu_ready, 1);
      cycle();
      check("r37_out_we", out_we, 0);
      fpu_valid = 0;
      issue_valid = 1; issue_rd = 0; ars1 = 9; ars2 = 0;
      #1;
      check("r37_busy_kept", issue_stall, 1);
      cycle();
      issue_valid = 0;

      // reissue of r7 on the edge its write retires keeps it busy
      do_reset();
      alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
      cycle();
      alu_valid = 0;
      check("r38_we", out_we, 1);
      check("r38_rd", out_rd, 7);
      issue_valid = 1; issue_rd = 7; ars1 = 0; ars2 = 0;
      #1;
      check("r38_no_stall", issue_stall, 0);
      cycle();
      issue_rd = 1; ars1 = 7;
      #1;
      check("r38_stall", issue_stall, 1);
      cycle();
      issue_valid = 0;

      // reset drops in-flight writes and busy bits
      do_reset();
      issue_valid = 1; issue_rd = 3; ars1 = 0; ars2 = 0;
      cycle();
      issue_valid = 0;
      mem_valid = 1; mem_rd = 3; mem_data = 32'h55;
      cycle();
      mem_data = 32'h66;
      rstn = 0;
      cycle();
      check("r39_out_we", out_we, 0);
      rstn = 1;
      mem_valid = 0;
      issue_valid = 1; issue_rd = 4; ars1 = 3; ars2 = 0;
      #1;
      check("r39_stall", issue_stall, 0);
      cycle();
      issue_valid = 0;

      // random traffic with sources honouring hold-until-accepted
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if (win_m == W_MEM) mem_valid = 0;
         if (win_m == W_FPU) fpu_valid = 0;
         if (!rstn) begin mem_valid = 0; fpu_valid = 0; end
         rstn = ($urandom_range(0, 59) != 0);
         if (!mem_valid && $urandom_range(0, 1) == 1) begin
            mem_valid = 1; mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
         end
         if (!fpu_valid && $urandom_range(0, 1) == 1) begin
            fpu_valid = 1; fpu_rd = 5'($urandom_range(0, 7)); fpu_data = $urandom;
         end
         alu_valid   = ($urandom_range(0, 3) == 0);
         alu_rd      = 5'($urandom_range(0, 7));
         alu_data    = $urandom;
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_rd    = 5'($urandom_range(0, 7));
         ars1        = 5'($urandom_range(0, 7));
         ars2        = 5'($urandom_range(0, 7));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
